// File: rtl/fir_xifu_pkg.sv
// Shared encodings, operation enum, issue-buffer entry layout and field helpers for the FIR XIFU.
package fir_xifu_pkg;

    localparam int unsigned FIR_XLEN     = 32;
    localparam int unsigned FIR_ID_WIDTH = 4;

    localparam logic [6:0] INSTR_OPCODE = 7'b0001011;
    localparam logic [2:0] XFIRLW       = 3'b000;
    localparam logic [2:0] XFIRSW       = 3'b001;
    localparam logic [2:0] XFIRDOTP     = 3'b010;

    typedef enum logic [1:0] {
        FIR_OP_NONE = 2'd0,
        FIR_OP_LW   = 2'd1,
        FIR_OP_SW   = 2'd2,
        FIR_OP_DOTP = 2'd3
    } fir_xifu_op_t;

    typedef struct packed {
        fir_xifu_op_t              op;
        logic [FIR_XLEN-1:0]       base;
        logic [FIR_XLEN-1:0]       data;
        logic [FIR_XLEN-1:0]       offset;
        logic [4:0]                rd;
        logic [FIR_ID_WIDTH-1:0]   id;
        logic                      committed;
        logic                      killed;
    } fir_xifu_idbuf_entry_t;

    function automatic logic [6:0] get_opcode(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [31:0] instr);
        return instr[14:12];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [11:0] get_imm_i(input logic [31:0] instr);
        return instr[31:20];
    endfunction

    function automatic logic [11:0] get_imm_s(input logic [31:0] instr);
        return {instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [FIR_XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(FIR_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/fir_xifu_id_decode.sv
// Combinational decode of an offered instruction into the X-interface response and EX operation.
module fir_xifu_id_decode
    import fir_xifu_pkg::*;
(
    input  logic                valid,
    input  logic [31:0]         instr,
    output logic                accept,
    output logic                writeback,
    output logic                loadstore,
    output fir_xifu_op_t        op,
    output logic [FIR_XLEN-1:0] offset,
    output logic [4:0]          rd
);

    // The rs1/rs2 register fields are resolved by the core; only their values reach us.
    logic unused_reg_fields;
    assign unused_reg_fields = ^instr[19:15];

    assign rd = get_rd(instr);

    always_comb begin
        accept    = 1'b0;
        writeback = 1'b0;
        loadstore = 1'b0;
        op        = FIR_OP_NONE;
        offset    = '0;
        if (valid && get_opcode(instr) == INSTR_OPCODE) begin
            case (get_funct3(instr))
                XFIRLW: begin
                    accept    = 1'b1;
                    writeback = 1'b1;
                    loadstore = 1'b1;
                    op        = FIR_OP_LW;
                    offset    = sext12(get_imm_i(instr));
                end
                XFIRSW: begin
                    accept    = 1'b1;
                    loadstore = 1'b1;
                    op        = FIR_OP_SW;
                    offset    = sext12(get_imm_s(instr));
                end
                XFIRDOTP: begin
                    accept    = 1'b1;
                    writeback = 1'b1;
                    op        = FIR_OP_DOTP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fir_xifu_id_buf.sv
// FIR XIFU decode/issue stage: in-order issue buffer holding entries until commit/kill, then feeding EX.
// Optional performance counters are enabled with `define FIR_XIFU_ID_PERF_EN.
module fir_xifu_id_buf
    import fir_xifu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned XLEN     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [31:0]                 issue_instr_i,
    input  logic [XLEN-1:0]             issue_rs1_i,
    input  logic [XLEN-1:0]             issue_rs2_i,
    input  logic [ID_WIDTH-1:0]         issue_id_i,
    output logic                        issue_accept_o,
    output logic                        issue_writeback_o,
    output logic                        issue_loadstore_o,
    input  logic                        commit_valid_i,
    input  logic [ID_WIDTH-1:0]         commit_id_i,
    input  logic                        commit_kill_i,
    output logic                        ex_valid_o,
    input  logic                        ex_ready_i,
    output logic [1:0]                  ex_op_o,
    output logic [XLEN-1:0]             ex_base_o,
    output logic [XLEN-1:0]             ex_data_o,
    output logic [XLEN-1:0]             ex_offset_o,
    output logic [4:0]                  ex_rd_o,
    output logic [ID_WIDTH-1:0]         ex_id_o,
    output logic [$clog2(DEPTH):0]      occupancy_o
`ifdef FIR_XIFU_ID_PERF_EN
    ,
    output logic [31:0]                 perf_accept_o,
    output logic [31:0]                 perf_reject_o,
    output logic [31:0]                 perf_kill_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fir_xifu_idbuf_entry_t mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  dec_accept;
    logic                  dec_writeback;
    logic                  dec_loadstore;
    fir_xifu_op_t          dec_op;
    logic [FIR_XLEN-1:0]   dec_offset;
    logic [4:0]            dec_rd;

    fir_xifu_id_decode u_decode (
        .valid     (issue_valid_i),
        .instr     (issue_instr_i),
        .accept    (dec_accept),
        .writeback (dec_writeback),
        .loadstore (dec_loadstore),
        .op        (dec_op),
        .offset    (dec_offset),
        .rd        (dec_rd)
    );

    assign issue_accept_o    = dec_accept;
    assign issue_writeback_o = dec_writeback;
    assign issue_loadstore_o = dec_loadstore;

    logic                  full;
    logic                  push;
    logic                  reject;
    logic                  kill_pop;
    logic                  pop;
    fir_xifu_idbuf_entry_t head_e;
    fir_xifu_idbuf_entry_t new_e;
    logic [DEPTH-1:0]      live;
    logic                  new_hit;

    assign full          = (count == CNT_W'(DEPTH));
    assign issue_ready_o = !full;
    assign push          = issue_valid_i && !full && dec_accept;
    assign reject        = issue_valid_i && !full && !dec_accept;

    assign head_e     = mem[head];
    assign ex_valid_o = (count != '0) && head_e.committed && !head_e.killed;
    assign kill_pop   = (count != '0) && head_e.killed;
    assign pop        = kill_pop || (ex_valid_o && ex_ready_i);

    assign ex_op_o     = head_e.op;
    assign ex_base_o   = XLEN'(head_e.base);
    assign ex_data_o   = XLEN'(head_e.data);
    assign ex_offset_o = XLEN'(head_e.offset);
    assign ex_rd_o     = head_e.rd;
    assign ex_id_o     = ID_WIDTH'(head_e.id);
    assign occupancy_o = count;

    // Entry i is live when its distance from head (mod DEPTH) is below the occupancy.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = CNT_W'(PTR_W'(PTR_W'(i) - head)) < count;
        end
    end

    // An instruction pushed alongside a matching commit picks up the event immediately.
    assign new_hit = commit_valid_i && (issue_id_i == commit_id_i);

    always_comb begin
        new_e           = '0;
        new_e.op        = dec_op;
        new_e.base      = FIR_XLEN'(issue_rs1_i);
        new_e.data      = FIR_XLEN'(issue_rs2_i);
        new_e.offset    = dec_offset;
        new_e.rd        = dec_rd;
        new_e.id        = FIR_ID_WIDTH'(issue_id_i);
        new_e.committed = new_hit && !commit_kill_i;
        new_e.killed    = new_hit && commit_kill_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && live[i] && (mem[i].id == FIR_ID_WIDTH'(commit_id_i))) begin
                    if (commit_kill_i) begin
                        mem[i].killed <= 1'b1;
                    end else begin
                        mem[i].committed <= 1'b1;
                    end
                end
            end
            if (push) begin
                mem[tail] <= new_e;
            end
            head <= head + PTR_W'(pop);
            tail <= tail + PTR_W'(push);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIR_XIFU_ID_PERF_EN
    logic [31:0] perf_accept;
    logic [31:0] perf_reject;
    logic [31:0] perf_kill;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            perf_accept <= '0;
            perf_reject <= '0;
            perf_kill   <= '0;
        end else begin
            perf_accept <= perf_accept + 32'(push);
            perf_reject <= perf_reject + 32'(reject);
            perf_kill   <= perf_kill + 32'(kill_pop);
        end
    end

    assign perf_accept_o = perf_accept;
    assign perf_reject_o = perf_reject;
    assign perf_kill_o   = perf_kill;
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_fir_xifu_id_buf.sv
// Directed self-checking bench for fir_xifu_id_buf (DEPTH=4, ID_WIDTH=4, XLEN=32).
module tb_fir_xifu_id_buf;

    localparam logic [6:0] OPC  = 7'b0001011;
    localparam logic [2:0] F_LW = 3'b000;
    localparam logic [2:0] F_SW = 3'b001;
    localparam logic [2:0] F_DP = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [3:0]  issue_id;
    logic        issue_accept;
    logic        issue_writeback;
    logic        issue_loadstore;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_op;
    logic [31:0] ex_base;
    logic [31:0] ex_data;
    logic [31:0] ex_offset;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_id;
    logic [2:0]  occupancy;
`ifdef FIR_XIFU_ID_PERF_EN
    logic [31:0] perf_accept;
    logic [31:0] perf_reject;
    logic [31:0] perf_kill;
`endif

    int passed = 0;
    int total  = 0;

    fir_xifu_id_buf #(.DEPTH(4), .ID_WIDTH(4), .XLEN(32)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .clear_i           (clear),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_instr_i     (issue_instr),
        .issue_rs1_i       (issue_rs1),
        .issue_rs2_i       (issue_rs2),
        .issue_id_i        (issue_id),
        .issue_accept_o    (issue_accept),
        .issue_writeback_o (issue_writeback),
        .issue_loadstore_o (issue_loadstore),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .ex_valid_o        (ex_valid),
        .ex_ready_i        (ex_ready),
        .ex_op_o           (ex_op),
        .ex_base_o         (ex_base),
        .ex_data_o         (ex_data),
        .ex_offset_o       (ex_offset),
        .ex_rd_o           (ex_rd),
        .ex_id_o           (ex_id),
        .occupancy_o       (occupancy)
`ifdef FIR_XIFU_ID_PERF_EN
        ,
        .perf_accept_o     (perf_accept),
        .perf_reject_o     (perf_reject),
        .perf_kill_o       (perf_kill)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, f3, rd, OPC};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm);
        return {imm[11:5], 5'd0, 5'd0, F_SW, imm[4:0], OPC};
    endfunction

    // Offers one instruction for a single cycle and returns the combinational response seen before the edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] id, output logic acc, output logic wb, output logic ls);
        issue_valid = 1'b1;
        issue_instr = instr;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_id    = id;
        #1;
        acc = issue_accept;
        wb  = issue_writeback;
        ls  = issue_loadstore;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        tick();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic drain(input string tag);
        ex_ready = 1'b1;
        for (int i = 0; i < 20 && occupancy != 3'd0; i++) tick();
        ex_ready = 1'b0;
        check(tag, 64'(occupancy), 64'd0);
    endtask

    logic        a, w, l;
    logic [3:0]  seen [$];
    logic [3:0]  seen0, seen1;
    logic [99:0] snap;

    initial begin
        rst_n = 1'b0; clear = 1'b0; issue_valid = 1'b0; issue_instr = '0; issue_rs1 = '0;
        issue_rs2 = '0; issue_id = '0; commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
        ex_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        check("rst_ready", 64'(issue_ready), 64'd1);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_exvalid", 64'(ex_valid), 64'd0);
        check("rst_exbase", 64'(ex_base), 64'd0);

        // XFIRLW imm=-4, rd=5, rs1=0x1000, id=3
        issue(enc_i(F_LW, 5'd5, 12'hFFC), 32'h1000, 32'h0, 4'd3, a, w, l);
        check("lw_resp", 64'({a, w, l}), 64'b111);
        check("lw_occ", 64'(occupancy), 64'd1);
        check("lw_nocommit_exvalid", 64'(ex_valid), 64'd0);
        commit(4'd3, 1'b0);
        check("lw_exvalid", 64'(ex_valid), 64'd1);
        check("lw_offset", 64'(ex_offset), 64'hFFFFFFFC);
        check("lw_base", 64'(ex_base), 64'h1000);
        check("lw_op", 64'(ex_op), 64'd1);
        check("lw_rd_id", 64'({ex_rd, ex_id}), 64'({5'd5, 4'd3}));
        drain("lw_drain");

        // XFIRSW imm=-2048
        issue(enc_s(12'h800), 32'h2000, 32'hCAFE, 4'd9, a, w, l);
        check("sw_resp", 64'({a, w, l}), 64'b101);
        commit(4'd9, 1'b0);
        check("sw_offset", 64'(ex_offset), 64'hFFFFF800);
        check("sw_op_data", 64'({ex_op, ex_data}), 64'({2'd2, 32'hCAFE}));
        drain("sw_drain");

        // Fill with four DOTPs
        for (int i = 0; i < 4; i++) begin
            issue(enc_i(F_DP, 5'(i + 10), 12'h0), 32'(i), 32'(i + 100), 4'(i), a, w, l);
            check("dp_resp", 64'({a, w, l}), 64'b110);
        end
        check("full_occ", 64'(occupancy), 64'd4);
        check("full_ready", 64'(issue_ready), 64'd0);
        commit(4'd0, 1'b0);
        check("full_head", 64'({ex_valid, ex_op, ex_offset}), 64'({1'b1, 2'd3, 32'd0}));
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check("full_pop_occ", 64'(occupancy), 64'd3);
        check("full_pop_ready", 64'(issue_ready), 64'd1);
        commit(4'd1, 1'b0); commit(4'd2, 1'b0); commit(4'd3, 1'b0);
        drain("dp_drain");

        // Kill in the middle of three entries
        for (int i = 1; i <= 3; i++) issue(enc_i(F_LW, 5'(i), 12'(i)), 32'(i), 32'h0, 4'(i), a, w, l);
        commit(4'd2, 1'b1);
        commit(4'd1, 1'b0);
        commit(4'd3, 1'b0);
        ex_ready = 1'b1;
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            if (ex_valid) seen.push_back(ex_id);
            tick();
        end
        ex_ready = 1'b0;
        seen0 = (seen.size() > 0) ? seen[0] : 4'hF;
        seen1 = (seen.size() > 1) ? seen[1] : 4'hF;
        check("kill_count", 64'(seen.size()), 64'd2);
        check("kill_first", 64'(seen0), 64'd1);
        check("kill_second", 64'(seen1), 64'd3);
        check("kill_occ", 64'(occupancy), 64'd0);
`ifdef FIR_XIFU_ID_PERF_EN
        check("perf_kill", 64'(perf_kill), 64'd1);
`endif

        // Unsupported funct3 and foreign opcode
        issue(enc_i(3'b111, 5'd1, 12'h0), 32'h0, 32'h0, 4'd7, a, w, l);
        check("unk_resp", 64'({a, w, l}), 64'b000);
        check("unk_occ", 64'(occupancy), 64'd0);
        issue({enc_i(F_LW, 5'd1, 12'h0)} ^ 32'h1, 32'h0, 32'h0, 4'd7, a, w, l);
        check("opc_resp", 64'({a, w, l}), 64'b000);
`ifdef FIR_XIFU_ID_PERF_EN
        check("perf_reject", 64'(perf_reject), 64'd2);
`endif

        // EX stall stability, then simultaneous push and pop
        issue(enc_i(F_LW, 5'd7, 12'h123), 32'hABCD, 32'h55, 4'd4, a, w, l);
        commit(4'd4, 1'b0);
        snap = {ex_valid, ex_op, ex_base, ex_data, ex_offset, ex_rd, ex_id};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_stable", 64'(snap ^ {ex_valid, ex_op, ex_base, ex_data, ex_offset, ex_rd, ex_id}), 64'd0);
        end
        check("stall_offset", 64'(ex_offset), 64'h123);
        ex_ready = 1'b1;
        issue(enc_i(F_DP, 5'd2, 12'h0), 32'h0, 32'h0, 4'd5, a, w, l);
        ex_ready = 1'b0;
        check("pushpop_occ", 64'(occupancy), 64'd1);
        check("pushpop_head", 64'({ex_valid, ex_id}), 64'({1'b0, 4'd5}));
        commit(4'd5, 1'b0);
        drain("pushpop_drain");

        // Clear with a committed head
        for (int i = 6; i <= 8; i++) issue(enc_i(F_LW, 5'(i), 12'h0), 32'(i), 32'h0, 4'(i), a, w, l);
        commit(4'd6, 1'b0);
        check("pre_clear", 64'({ex_valid, occupancy}), 64'({1'b1, 3'd3}));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_state", 64'({ex_valid, occupancy, ex_base}), 64'({1'b0, 3'd0, 32'd0}));
`ifdef FIR_XIFU_ID_PERF_EN
        check("clear_perf", 64'({perf_accept, perf_reject}), 64'd0);
`endif
        commit(4'd7, 1'b0);
        check("stale_commit_occ", 64'(occupancy), 64'd0);
        issue(enc_i(F_LW, 5'd1, 12'h0), 32'h0, 32'h0, 4'd7, a, w, l);
        tick();
        check("stale_commit_exvalid", 64'({ex_valid, occupancy}), 64'({1'b0, 3'd1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fir_xifu_id_buf.md
Name: fir_xifu_id_buf

Overview:
Parametrised decode/issue stage for the FIR XIFU coprocessor.
- Decodes custom-opcode instructions offered on the X-interface issue channel.
- Accepts supported ones into a DEPTH-entry in-order issue buffer.
- Holds each entry until the core commits or kills it, then releases committed entries to EX with a valid/ready handshake.
- Sits between the core's issue/commit channels and the XIFU EX stage.
- Adds backpressure, a multi-entry buffer and speculation handling over a single-register ID stage.

Parameters:
DEPTH, 4, issue buffer entries; power of two, >=2
ID_WIDTH, 4, width of the X-interface instruction id
XLEN, 32, register operand width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  synchronous flush, same effect as reset
issue_valid_i  in  1  core offers an instruction
issue_ready_o  out  1  buffer can take an instruction
issue_instr_i  in  32  instruction word
issue_rs1_i  in  XLEN  rs1 value (base address)
issue_rs2_i  in  XLEN  rs2 value
issue_id_i  in  ID_WIDTH  instruction id
issue_accept_o  out  1  instruction is supported
issue_writeback_o  out  1  instruction writes rd
issue_loadstore_o  out  1  instruction uses memory
commit_valid_i  in  1  commit event
commit_id_i  in  ID_WIDTH  id being committed
commit_kill_i  in  1  1 = kill, 0 = commit
ex_valid_o  out  1  head entry valid and committed
ex_ready_i  in  1  EX consumes head
ex_op_o  out  2  fir_xifu_op_t: LW=1, SW=2, DOTP=3
ex_base_o  out  XLEN  rs1 value
ex_data_o  out  XLEN  rs2 value
ex_offset_o  out  XLEN  sign-extended immediate
ex_rd_o  out  5  rd field
ex_id_o  out  ID_WIDTH  id
occupancy_o  out  $clog2(DEPTH)+1  live entries

Behaviour:
- Reset (rst_ni=0 at clk edge) or clear_i=1: buffer empty, pointers 0, all flags 0, ex_valid_o=0, occupancy_o=0, issue_ready_o=1, ex_* outputs 0.
- Decode (combinational): applies only when opcode == INSTR_OPCODE and issue_valid_i=1. Otherwise accept, writeback and loadstore are 0.
  - funct3 XFIRLW: accept=1, writeback=1, loadstore=1; offset = I-immediate.
  - funct3 XFIRSW: accept=1, writeback=0, loadstore=1; offset = S-immediate.
  - funct3 XFIRDOTP: accept=1, writeback=1, loadstore=0; offset = 0.
  - Any other funct3: all response bits 0.
- Offsets are sign-extended from 12 bits to XLEN.
- issue_ready_o = !full. It does not depend on decode or on a same-cycle pop; no pass-through when full.
- Push: issue_valid_i & issue_ready_o & accept. Writes op, rs1, rs2, offset, rd, id to the tail, with committed=0 and killed=0.
- A handshake with accept=0 completes with no push.
- Commit event (commit_valid_i=1): for every live entry with id == commit_id_i, sets committed=1, or killed=1 when commit_kill_i=1.
  - An entry pushed in the same cycle with a matching id is also updated.
  - Commits for absent ids are ignored.
- Head handling:
  - Head killed: popped automatically in one cycle, not presented to EX.
  - Head committed and not killed: ex_valid_o=1.
  - Pop happens on ex_valid_o & ex_ready_i.
  - ex_* outputs are driven from the head register: zero combinational path from issue to EX; minimum issue-to-ex_valid_o latency is 1 cycle after commit.
- ex_* outputs stay stable while ex_valid_o=1 and ex_ready_i=0.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo DEPTH.
- Full: occupancy_o == DEPTH; issue_valid_i is held off by the core.
- Reset or clear mid-operation discards all entries, including committed ones.

Optional Feature:
FIR_XIFU_ID_PERF_EN:
- Defined: adds ports perf_accept_o[31:0] (pushes), perf_reject_o[31:0] (handshakes with accept=0) and perf_kill_o[31:0] (killed entries popped). Counters are zeroed by reset/clear and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- fir_xifu_pkg holds:
  - INSTR_OPCODE and the three funct3 constants;
  - the fir_xifu_op_t enum;
  - the buffer entry struct fir_xifu_idbuf_entry_t (op, base, data, offset, rd, id, committed, killed);
  - field-extract and immediate-extract functions.
- One sub-module, fir_xifu_id_decode: purely combinational instr -> accept/writeback/loadstore/op/offset.

Test Plan:
- Reset then issue XFIRLW (imm=-4, rs1=0x1000, id=3), then commit id 3 → accept/wb/ls=1/1/1; ex_valid_o the cycle after commit; ex_offset_o=0xFFFFFFFC; ex_base_o=0x1000; ex_op_o=1.
- Push 4 XFIRDOTP without commit (DEPTH=4) → occupancy_o=4, issue_ready_o=0; commit id0, ex_ready_i=1 → pop, issue_ready_o=1 next cycle.
- Issue ids 1,2,3; kill id 2; commit ids 1,3 → EX sees ids 1 then 3 only; occupancy_o reaches 0.
- Unknown funct3 with issue_valid_i=1 → accept=0, occupancy unchanged (perf_reject_o increments when FIR_XIFU_ID_PERF_EN defined).
- ex_ready_i held 0 for 5 cycles with committed head → ex_* outputs constant; then a same-cycle push and pop → occupancy unchanged.
- clear_i with 3 entries (one committed) → next cycle ex_valid_o=0, occupancy_o=0; a later commit for a cleared id has no effect.
